// File: rtl/lut_rr_arbiter.sv
// lut_rr_arbiter: round-robin arbiter that lets NREQ requesters share one
// 3-bit -> 2-bit code-mapping table.
//
// The winner's mapped code is registered and tagged with the winner's ID. It is
// then held with valid/ready until the consumer accepts it. Only one result is
// ever outstanding, so grants are spaced at least two cycles apart.
//
// Optional build macro LUT_ARB_STATS_EN adds a 16-bit wrapping counter of
// accepted transactions on output port stat_count.
module lut_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [3*NREQ-1:0] w_in,
  output logic [NREQ-1:0]   gnt,
  output logic [1:0]        f_out,
  output logic [IDW-1:0]    f_id,
  output logic              f_valid,
`ifdef LUT_ARB_STATS_EN
  output logic [15:0]       stat_count,
`endif
  input  logic              f_ready
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [IDW-1:0]      ptr_q, ptr_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [1:0]          f_out_q, f_out_d;
  logic [IDW-1:0]      f_id_q, f_id_d;
  logic                f_valid_q, f_valid_d;

  logic [1:0]          map_val [NREQ];
  logic                win_found;
  logic [IDW-1:0]      win_id;
  logic [IDW:0]        cand;

  // Fixed code table: W -> F.
  function automatic logic [1:0] lut_map(input logic [2:0] w);
    logic [1:0] f;
    case (w)
      3'd0:    f = 2'd3;
      3'd1:    f = 2'd0;
      3'd2:    f = 2'd1;
      3'd3:    f = 2'd2;
      3'd4:    f = 2'd2;
      3'd5:    f = 2'd1;
      3'd6:    f = 2'd0;
      default: f = 2'd3;
    endcase
    return f;
  endfunction

  // Map every requester's code in parallel. The winner's entry is picked later.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_map
      assign map_val[gi] = lut_map(w_in[3*gi +: 3]);
    end
  endgenerate

  // Circular priority scan starting at ptr_q. The first active request wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      if (!win_found && req[cand[IDW-1:0]]) begin
        win_found = 1'b1;
        win_id    = cand[IDW-1:0];
      end
    end
  end

  // Next-state and output logic. Outputs hold unless a grant or an accept occurs.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = '0;
    f_out_d   = f_out_q;
    f_id_d    = f_id_q;
    f_valid_d = f_valid_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          gnt_d     = NREQ'(1) << win_id;
          f_out_d   = map_val[win_id];
          f_id_d    = win_id;
          f_valid_d = 1'b1;
          ptr_d     = (win_id == IDW'(NREQ-1)) ? '0 : win_id + 1'b1;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (f_ready) begin
          f_valid_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers. Reset clears them without waiting for a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      f_out_q   <= '0;
      f_id_q    <= '0;
      f_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      f_out_q   <= f_out_d;
      f_id_q    <= f_id_d;
      f_valid_q <= f_valid_d;
    end
  end

  assign gnt     = gnt_q;
  assign f_out   = f_out_q;
  assign f_id    = f_id_q;
  assign f_valid = f_valid_q;

`ifdef LUT_ARB_STATS_EN
  logic [15:0] stat_count_q;

  // Count accepted transactions. The counter wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_count_q <= '0;
    end else if (state_q == HOLD && f_ready) begin
      stat_count_q <= stat_count_q + 16'd1;
    end
  end

  assign stat_count = stat_count_q;
`endif

endmodule

// File: tb/tb_lut_rr_arbiter.sv
// Testbench for lut_rr_arbiter.
// A transaction-level reference model predicts every output after every clock
// edge. Directed scenarios come first, followed by randomized traffic.
module tb_lut_rr_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [3*NREQ-1:0] w_in;
  logic [NREQ-1:0]   gnt;
  logic [1:0]        f_out;
  logic [IDW-1:0]    f_id;
  logic              f_valid;
  logic              f_ready;
`ifdef LUT_ARB_STATS_EN
  logic [15:0]       stat_count;
`endif

  lut_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .w_in      (w_in),
    .gnt       (gnt),
    .f_out     (f_out),
    .f_id      (f_id),
    .f_valid   (f_valid),
`ifdef LUT_ARB_STATS_EN
    .stat_count(stat_count),
`endif
    .f_ready   (f_ready)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference table and transaction-level model state.
  int lut_tab [8] = '{3, 0, 1, 2, 2, 1, 0, 3};
  bit m_busy;
  int m_ptr, m_gnt, m_out, m_id, m_valid, m_cnt;
  int seen_id[$];
  int seen_out[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_ptr = 0; m_gnt = 0; m_out = 0; m_id = 0; m_valid = 0; m_cnt = 0;
  endtask

  // Apply one clock edge to the model, using the inputs that the DUT sees.
  task automatic model_edge();
    int w;
    m_gnt = 0;
    if (reset) begin
      model_reset();
    end else if (!m_busy) begin
      if (req != 0) begin
        w = -1;
        for (int off = 0; off < NREQ; off++) begin
          if (w < 0 && req[(m_ptr + off) % NREQ]) w = (m_ptr + off) % NREQ;
        end
        m_gnt   = 1 << w;
        m_out   = lut_tab[(w_in >> (3*w)) & 7];
        m_id    = w;
        m_valid = 1;
        m_ptr   = (w + 1) % NREQ;
        m_busy  = 1;
      end
    end else if (f_ready) begin
      m_busy  = 0;
      m_valid = 0;
      m_cnt   = (m_cnt + 1) % 65536;
    end
  endtask

  task automatic compare_all();
    check_val("gnt", 32'(gnt), 32'(m_gnt));
    check_val("f_valid", 32'(f_valid), 32'(m_valid));
    check_val("f_out", 32'(f_out), 32'(m_out));
    check_val("f_id", 32'(f_id), 32'(m_id));
`ifdef LUT_ARB_STATS_EN
    check_val("stat_count", 32'(stat_count), 32'(m_cnt));
`endif
  endtask

  // One clock cycle: the edge, then the model update, then the checks 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    if (gnt !== '0) begin
      seen_id.push_back(int'(f_id));
      seen_out.push_back(int'(f_out));
      $display("grant id=%0d f_out=%0d t=%0t", f_id, f_out, $time);
    end
  endtask

  int exp_ids  [5] = '{0, 1, 2, 3, 0};
  int exp_outs [5] = '{3, 2, 2, 3, 3};

  initial begin
    reset = 1'b1; req = '0; w_in = '0; f_ready = 1'b0;
    model_reset();
    #2;
    compare_all();                        // Outputs after reset.
    tick();
    reset = 1'b0;

    // Scenario: single request from requester 2 with code 5.
    req = 4'b0100; w_in = 12'(5) << 6;
    tick();
    check_val("t2_gnt", 32'(gnt), 32'h4);
    req = '0; f_ready = 1'b0;
    tick();
    f_ready = 1'b1;
    tick();
    check_val("t2_drop", 32'(f_valid), 32'd0);

    // Scenario: hold the result with f_ready low, then reset between edges.
    req = 4'b1111; f_ready = 1'b0; w_in = $urandom;
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    model_reset();
    compare_all();                        // Reset must act before the next edge.
    tick();
    reset = 1'b0; req = 4'b0010;
    tick();
    check_val("t1_regrant", 32'(gnt), 32'h2);

    // Scenario: fairness with all requesters active and codes 0,3,4,7.
    reset = 1'b1; tick(); reset = 1'b0;
    seen_id.delete(); seen_out.delete();
    req = 4'b1111; w_in = {3'd7, 3'd4, 3'd3, 3'd0}; f_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check_val("t3_count", 32'(seen_id.size()), 32'd5);
    for (int i = 0; i < 5 && i < seen_id.size(); i++) begin
      check_val("t3_id", 32'(seen_id[i]), 32'(exp_ids[i]));
      check_val("t3_out", 32'(seen_out[i]), 32'(exp_outs[i]));
    end

    // Scenario: consumer stalls for 5 cycles after a grant.
    f_ready = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    f_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    // Scenario: requester 0 sweeps every code.
    req = 4'b0001;
    for (int w = 0; w < 8; w++) begin
      w_in = 12'(w);
      tick();
      tick();
    end

    // Randomized traffic, with the occasional reset.
    for (int i = 0; i < 400; i++) begin
      req     = NREQ'($urandom);
      w_in    = 12'($urandom);
      f_ready = ($urandom_range(0, 3) != 0);
      reset   = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
